// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one A + zero-extended B adder between NUM_REQ requesters.
// Each granted operation is summed, registered once and presented with its requester ID
// on a single valid/ready result port that supports backpressure.
// Optional: define ADDER_ARB_STALL_CNT_EN to add a 32-bit result-stall cycle counter.
module adder_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned A_W     = 50,
    parameter int unsigned B_W     = 12,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [A_W:0]           res_sum,
    output logic [ID_W-1:0]        res_id
`ifdef ADDER_ARB_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    logic            res_valid_q, res_valid_d;
    logic [A_W:0]    res_sum_q, res_sum_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic            slot_free;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic            xfer;
    logic [A_W-1:0]  a_sel;
    logic [B_W-1:0]  b_sel;

    // The output register can take a new sum when empty or being drained this cycle.
    assign slot_free = !res_valid_q || res_ready;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping mod NUM_REQ.
    always_comb begin
        logic [ID_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + 32'(k)) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // One-hot ready to the winner only; suppressed in reset and while the result stalls.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        if (!reset && slot_free && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_idx;
            xfer      = 1'b1;
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                a_sel = req_a[i*A_W +: A_W];
                b_sel = req_b[i*B_W +: B_W];
            end
        end
    end

    // Next state: load on transfer, drop valid on a handshake without refill, else hold.
    always_comb begin
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_sum_d   = {1'b0, a_sel} + (A_W+1)'(b_sel);
            res_id_d    = grant_idx;
            rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // Result register and round-robin pointer with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;

`ifdef ADDER_ARB_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles a result waits on downstream; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (res_valid_q && !res_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 50-bit + 12-bit zero-extending adder between NUM_REQ requesters, e.g. the MAC accumulate path and address/offset units.
- Round-robin arbitration; each requester uses a valid/ready handshake.
- Each sum is registered once, tagged with the ID of the winning requester and presented on a single valid/ready result port with backpressure.
- Sits between the multiply/accumulate issue logic and the 51-bit result writeback.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_W, 50, width of operand A.
- B_W, 12, width of operand B (B_W <= A_W); B is zero-extended to A_W.
- ID_W, 2, result-tag width, must equal max(1, ceil(log2(NUM_REQ))).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_W  operand A of requester i at bits [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  operand B of requester i at bits [i*B_W +: B_W].
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts result.
- res_sum  out  A_W+1  A + zero-extended B, carry in MSB.
- res_id  out  ID_W  index of requester that produced res_sum.

Behaviour:
- Reset values:
  - res_valid=0, res_sum=0, res_id=0, rr_ptr=0.
  - req_ready is all-zero while reset is high.
- Slot free: slot_free = !res_valid || res_ready.
- Grant:
  - Only when slot_free and not reset.
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[i]=1 only for the granted i; it is combinational from req_valid, rr_ptr and res_valid/res_ready.
  - A transfer occurs when req_valid[i] && req_ready[i].
- On a transfer from i (cycle t):
  - res_sum <= {1'b0,req_a[i]} + {zero ext, req_b[i]}.
  - res_id <= i; res_valid <= 1 in t+1 (latency 1).
  - rr_ptr <= (i+1) mod NUM_REQ.
- No transfer, res_valid && res_ready: res_valid <= 0.
- res_valid && !res_ready (stall):
  - res_sum/res_id hold; no grants (req_ready all zero).
- Throughput: one operation per cycle while res_ready=1; a result handoff and a new grant in the same cycle are legal.
- Requester side:
  - Requesters hold operands stable while valid and not ready.
  - The arbiter does not latch ungranted requests.
  - A request dropping valid before grant is ignored.
- rr_ptr changes only on transfer; no request means rr_ptr holds.
- Arithmetic: unsigned.
  - All-ones A + all-ones B gives carry in bit A_W.
  - No saturation, no overflow flag.
- State view:
  - EMPTY (res_valid=0) -> FULL on transfer.
  - FULL -> EMPTY on handshake with no new transfer.
  - FULL -> FULL on handshake plus transfer, or on stall.
- Reset mid-operation: pending result discarded, rr_ptr returns to 0, the next cycle behaves as after power-up.

Optional Feature:
- Macro ADDER_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0].
  - Increments each cycle res_valid && !res_ready; wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Single request: req0 A=0x3_FFFF_FFFF_FFFF, B=0x001, res_ready=1 -> next cycle res_valid=1, res_sum=0x4_0000_0000_0000, res_id=0.
- Carry out: A=all-ones (50b), B=0xFFF -> res_sum=0x4_0000_0000_0FFE (bit 50 set).
- Round-robin: all 4 requesters valid continuously, res_ready=1 -> grants 0,1,2,3,0 in consecutive cycles; res_id sequence matches one cycle later.
- Backpressure: result pending, res_ready=0 for 3 cycles with req1 valid -> req_ready stays 0, res_sum/res_id stable. Raise res_ready -> req1 granted the same cycle, its result the next cycle. With macro defined, stall_cnt=3.
- Pointer skip: rr_ptr=1, only req3 and req0 valid -> req3 granted first, rr_ptr becomes 0, then req0 granted.
- Reset mid-flight: assert reset while res_valid=1 -> next cycle res_valid=0, res_id=0, req_ready=0. After release, req2 alone is granted and rr_ptr becomes 3.
